uram_access_ctrl: RTL and testbench
===================================

Name: uram_access_ctrl

Overview:
Sequencer and arbiter in front of one ultraram_simple_dual_port instance in the feature-match path.
- After reset, clears all DEPTH words to zero, then serves traffic.
- Shares the single read port among NREQ descriptor-fetch requesters, round-robin.
- Passes one writer straight to the write port.
- Tags every issued read and returns RAM data with the requester ID at fixed latency.

Parameters:
- DEPTH, 1000, RAM word count; AW = $clog2(DEPTH).
- DWIDTH, 512, data width.
- NREQ, 4, number of read requesters (2..8); IDW = $clog2(NREQ).
- RD_LAT, 6, cycles from ram_mem_en&&read issue to ram_o_valid (NBPIPE+2 for NBPIPE=4).

Ports:
- clk  in  1  clock
- rstb  in  1  asynchronous active-low reset
- wr_req  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  DWIDTH  write data
- wr_ack  out  1  write accepted this cycle
- rd_req  in  NREQ  per-requester read request, held until granted
- rd_addr  in  NREQ*AW  packed read addresses, slice i for requester i
- rd_gnt  out  NREQ  one-hot grant; read issued this cycle
- rsp_valid  out  1  read data valid
- rsp_id  out  IDW  requester owning rsp_data
- rsp_data  out  DWIDTH  read data
- init_done  out  1  clear sweep finished
- lat_err  out  1  sticky: ram_o_valid disagreed with tag pipeline
- ram_mem_en, ram_wea, ram_regceb  out  1 each  RAM controls
- ram_addra, ram_addrb  out  AW each  RAM addresses
- ram_dina  out  DWIDTH  RAM write data
- ram_o_valid  in  1  RAM output valid
- ram_doutb  in  DWIDTH  RAM output data

Behaviour:
Reset values:
- All outputs are 0 and rr_ptr = 0.
- FSM is in CLEAR with clr_addr = 0.
- ram_rstb for the RAM is driven by the instantiating level, not by this block.

FSM, states CLEAR -> RUN:
- CLEAR, per cycle: ram_mem_en=1, ram_wea=1, ram_addra=clr_addr, ram_dina=0, clr_addr++.
  - wr_ack=0 and rd_gnt=0 throughout.
  - When clr_addr==DEPTH-1 is written, go to RUN next cycle and set init_done=1 (held until reset).
- RUN, writes:
  - wr_ack = wr_req, same cycle (combinational).
  - ram_wea = wr_req; ram_addra/ram_dina pass through.
  - Writes never stall.
- RUN, reads:
  - Round-robin arbiter picks the first asserted rd_req at or after rr_ptr, wrapping from NREQ-1 to 0.
  - rd_gnt is combinational, at most one bit set.
  - On grant to i: ram_addrb = slice i; rr_ptr <= (i+1) mod NREQ.
  - No request: rr_ptr holds.
- RAM drive in RUN: ram_mem_en = any grant OR wr_req. ram_regceb = 1 constantly.

Tag pipeline:
- RD_LAT-deep shift register of {valid, id}, shifting every cycle.
- Stage 0 is loaded with {read_issued, granted id}.
- At the last stage: rsp_valid = stage valid, rsp_id = stage id, rsp_data = ram_doutb. These are combinational outputs of the stage, aligned with ram_o_valid.
- If stage valid != ram_o_valid in any cycle, lat_err <= 1 (sticky until reset).

Boundaries and simultaneous events:
- Read and write to the same address in the same cycle: the response carries OLD data, unless RAW_STALL_EN is defined.
- Back-to-back grants: one per cycle, full throughput, up to RD_LAT reads in flight.
- All NREQ requesting continuously: each is granted exactly once every NREQ cycles.
- A requester dropping rd_req while ungranted: legal, no grant.
- Reset asserted mid-operation: tag pipeline is flushed and in-flight responses are discarded (rsp_valid=0). FSM restarts CLEAR from address 0.

Optional Feature:
Macro: URAM_ACCESS_CTRL_RAW_STALL_EN.
- Defined: in RUN, if wr_req && the selected requester's address == wr_addr, the read is suppressed for that cycle.
  - No grant is issued and rr_ptr holds.
  - The requester is re-arbitrated next cycle, so the response returns NEW data.
  - Writes still never stall.
- Undefined: no comparator; same-cycle collision returns old data.

Decomposition:
- Package uram_ctrl_pkg holds:
  - FSM state enum {CLEAR, RUN}.
  - Default RD_LAT constant.
  - Function for the round-robin first-set-from-pointer search.
- One sub-module: uram_rr_arbiter (NREQ-wide round-robin, inputs req/ptr, outputs one-hot gnt/idx).
- Tag pipeline and FSM stay in the top module.

Test Plan:
- Reset release, DEPTH=16 → exactly 16 write cycles, addresses 0..15 with data 0; init_done rises on cycle 17. Then read every address → all rsp_data=0, rsp_id correct.
- Write addr 5 = 0xA5…A5. Several cycles later, requester 2 reads addr 5 → rsp_valid exactly RD_LAT cycles after grant, rsp_id=2, data 0xA5…A5, lat_err=0.
- All 4 requesters hold rd_req for 12 cycles → grant order 0,1,2,3,0,1,… One response per cycle, ids in the same order.
- Same cycle: write addr 9 = 0x11, requester 1 reads addr 9 (old value 0x22):
  - Macro off → response 0x22.
  - Macro on → grant delayed one cycle, response 0x11.
- rstb pulsed low while 3 reads are in flight → no rsp_valid after release until new grants. CLEAR restarts at address 0; init_done=0 until the sweep completes.
- Model the RAM with latency RD_LAT+1 → lat_err sets on the first response and stays 1.

Source files
------------

// File: rtl/uram_ctrl_pkg.sv
// Shared types and helpers for the URAM access controller: FSM states, default read
// latency, and the round-robin first-set search used by the read arbiter.
package uram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int RD_LAT_DEF = 6;

    // Widest requester set the search function supports.
    localparam int RR_MAX = 8;

    // Returns the index of the first set bit of req at or after ptr, wrapping at n, or -1.
    function automatic int rr_first(input logic [RR_MAX-1:0] req, input int ptr, input int n);
        int pick;
        int c;
        pick = -1;
        for (int k = 0; k < RR_MAX; k++) begin
            c = ptr + k;
            if (c >= n) c = c - n;
            if (k < n && pick < 0 && req[c[2:0]]) pick = c;
        end
        return pick;
    endfunction

endpackage

// File: rtl/uram_access_ctrl_if.sv
// Client-side bus of the URAM access controller: one write port, NREQ read requesters
// and the tagged read-response channel.
interface uram_access_ctrl_if #(
    parameter int AW     = 10,
    parameter int DWIDTH = 512,
    parameter int NREQ   = 4,
    parameter int IDW    = $clog2(NREQ)
);
    logic                 wr_req;
    logic [AW-1:0]        wr_addr;
    logic [DWIDTH-1:0]    wr_data;
    logic                 wr_ack;
    logic [NREQ-1:0]      rd_req;
    logic [NREQ*AW-1:0]   rd_addr;
    logic [NREQ-1:0]      rd_gnt;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [DWIDTH-1:0]    rsp_data;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_gnt, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_gnt, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/uram_rr_arbiter.sv
// NREQ-wide round-robin arbiter: grants the first request at or after ptr, one-hot.
module uram_rr_arbiter
    import uram_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            valid
);
    logic [RR_MAX-1:0] req_ext;
    int                pick;

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
        pick              = rr_first(req_ext, int'(ptr), NREQ);
        valid             = (pick >= 0);
        idx               = valid ? pick[IDW-1:0] : '0;
        gnt               = valid ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uram_access_ctrl.sv
// Clears the URAM after reset, then arbitrates reads round-robin and returns tagged data.
// Optional macro URAM_ACCESS_CTRL_RAW_STALL_EN holds off a read hitting a same-cycle write.
module uram_access_ctrl
    import uram_ctrl_pkg::*;
#(
    parameter  int DEPTH  = 1000,
    parameter  int DWIDTH = 512,
    parameter  int NREQ   = 4,
    parameter  int RD_LAT = RD_LAT_DEF,
    localparam int AW     = $clog2(DEPTH),
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rstb,
    uram_access_ctrl_if.slave    bus,
    output logic                 init_done,
    output logic                 lat_err,
    output logic                 ram_mem_en,
    output logic                 ram_wea,
    output logic                 ram_regceb,
    output logic [AW-1:0]        ram_addra,
    output logic [AW-1:0]        ram_addrb,
    output logic [DWIDTH-1:0]    ram_dina,
    input  logic                 ram_o_valid,
    input  logic [DWIDTH-1:0]    ram_doutb
);
    state_e                      state_q, state_d;
    logic [AW-1:0]               clr_addr_q, clr_addr_d;
    logic                        clr_en_q, clr_en_d;
    logic                        regce_q;
    logic                        init_done_q, init_done_d;
    logic [IDW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [RD_LAT-1:0]           tag_v_q, tag_v_d;
    logic [RD_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic                        lat_err_q, lat_err_d;

    logic [NREQ-1:0]             req_run;
    logic [NREQ-1:0]             arb_gnt;
    logic [IDW-1:0]              arb_idx;
    logic                        arb_valid;
    logic [AW-1:0]               sel_addr;
    logic                        raw_hit;
    logic                        read_issued;

    assign req_run  = (state_q == RUN) ? bus.rd_req : '0;

    uram_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_run),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_addr = bus.rd_addr[int'(arb_idx)*AW +: AW];

`ifdef URAM_ACCESS_CTRL_RAW_STALL_EN
    assign raw_hit = bus.wr_req && (sel_addr == bus.wr_addr);
`else
    assign raw_hit = 1'b0;
`endif

    assign read_issued = arb_valid && !raw_hit;

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        bus.wr_ack = 1'b0;
        bus.rd_gnt = '0;
        ram_mem_en = 1'b0;
        ram_wea    = 1'b0;
        ram_addra  = clr_addr_q;
        ram_dina   = '0;
        ram_addrb  = '0;
        if (state_q == CLEAR) begin
            ram_mem_en = clr_en_q;
            ram_wea    = clr_en_q;
        end else begin
            bus.wr_ack = bus.wr_req;
            ram_wea    = bus.wr_req;
            ram_addra  = bus.wr_addr;
            ram_dina   = bus.wr_data;
            ram_mem_en = read_issued || bus.wr_req;
            if (read_issued) begin
                bus.rd_gnt = arb_gnt;
                ram_addrb  = sel_addr;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_en_d    = clr_en_q;
        init_done_d = init_done_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            CLEAR: begin
                // First cycle out of reset only arms the sweep, keeping all outputs low in reset.
                clr_en_d = 1'b1;
                if (clr_en_q) begin
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        state_d     = RUN;
                        clr_en_d    = 1'b0;
                        init_done_d = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (read_issued) rr_ptr_d = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            default: state_d = CLEAR;
        endcase
        tag_v_d   = {tag_v_q[RD_LAT-2:0], read_issued};
        tag_id_d  = {tag_id_q[RD_LAT-2:0], arb_idx};
        lat_err_d = lat_err_q || (tag_v_q[RD_LAT-1] != ram_o_valid);
    end

    // NOTE: state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            clr_en_q    <= 1'b0;
            regce_q     <= 1'b0;
            init_done_q <= 1'b0;
            rr_ptr_q    <= '0;
            // NOTE: the tag shift register is reset so in-flight reads are dropped; RAM contents
            // are not reset but rewritten by the clear sweep.
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            lat_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_en_q    <= clr_en_d;
            regce_q     <= 1'b1;
            init_done_q <= init_done_d;
            rr_ptr_q    <= rr_ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            lat_err_q   <= lat_err_d;
        end
    end

    assign bus.rsp_valid = tag_v_q[RD_LAT-1];
    assign bus.rsp_id    = tag_id_q[RD_LAT-1];
    assign bus.rsp_data  = ram_doutb;
    assign init_done     = init_done_q;
    assign lat_err       = lat_err_q;
    assign ram_regceb    = regce_q;

endmodule

// File: tb/tb_uram_access_ctrl.sv
// Self-checking bench for uram_access_ctrl: behavioural URAM, scoreboard reference model,
// a round-robin vector table and directed corner-case sequences.
module tb_uram_access_ctrl;
    localparam int DEPTH  = 16;
    localparam int DWIDTH = 32;
    localparam int NREQ   = 4;
    localparam int RD_LAT = 6;
    localparam int AW     = $clog2(DEPTH);
    localparam int IDW    = $clog2(NREQ);
`ifdef URAM_ACCESS_CTRL_RAW_STALL_EN
    localparam int          EXP_RAW_OFF  = 1;
    localparam logic [31:0] EXP_RAW_DATA = 32'h11;
`else
    localparam int          EXP_RAW_OFF  = 0;
    localparam logic [31:0] EXP_RAW_DATA = 32'h22;
`endif

    logic clk = 1'b0;
    logic rstb;
    logic init_done, lat_err;
    logic ram_mem_en, ram_wea, ram_regceb, ram_o_valid;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic [DWIDTH-1:0] ram_dina, ram_doutb;

    always #5 clk = ~clk;

    uram_access_ctrl_if #(.AW(AW), .DWIDTH(DWIDTH), .NREQ(NREQ)) bus ();

    uram_access_ctrl #(.DEPTH(DEPTH), .DWIDTH(DWIDTH), .NREQ(NREQ), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rstb(rstb), .bus(bus), .init_done(init_done), .lat_err(lat_err),
        .ram_mem_en(ram_mem_en), .ram_wea(ram_wea), .ram_regceb(ram_regceb),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb), .ram_dina(ram_dina),
        .ram_o_valid(ram_o_valid), .ram_doutb(ram_doutb)
    );

    // Behavioural URAM: read-before-write, output after ram_lat cycles.
    int ram_lat = RD_LAT;
    logic [DWIDTH-1:0] ram_mem [DEPTH];
    bit seeded;
    logic [15:0] pipe_v;
    logic [DWIDTH-1:0] pipe_d [16];

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[14:0], ram_mem_en && (|bus.rd_gnt)};
            for (int i = 15; i > 0; i--) pipe_d[i] <= pipe_d[i-1];
            pipe_d[0] <= ram_mem[ram_addrb];
        end
    end

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'hDEADBEEF;
            seeded <= 1'b1;
        end else if (ram_mem_en && ram_wea) begin
            ram_mem[ram_addra] <= ram_dina;
        end
    end

    assign ram_o_valid = pipe_v[ram_lat-1];
    assign ram_doutb   = pipe_d[ram_lat-1];

    // Reference model state
    typedef struct { int due; int id; logic [DWIDTH-1:0] data; } rsp_t;
    rsp_t q[$];
    logic [DWIDTH-1:0] m_mem [DEPTH];
    int m_ptr = 0;
    bit m_lat_err = 1'b0;
    int since_rst = 0;
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct { logic [NREQ-1:0] req; logic wr; logic [NREQ-1:0] gnt; logic ack; } vec_t;
    vec_t vt [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] slice(input logic [NREQ*AW-1:0] v, input int i);
        return v[i*AW +: AW];
    endfunction

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        bus.rd_addr[i*AW +: AW] = a;
    endtask

    // Called right after inputs are driven at a negedge: predicts and checks this cycle.
    task automatic tick();
        logic [NREQ-1:0] eg;
        int pick;
        bit run, due;
        rsp_t r;
        #1;
        run = rstb && (since_rst >= DEPTH + 1);
        if (!rstb) begin
            q.delete();
            m_lat_err = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            check("rst_mem_en", ram_mem_en, 1'b0);
            check("rst_regceb", ram_regceb, 1'b0);
        end
        eg = '0;
        pick = -1;
        if (run) begin
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && bus.rd_req[(m_ptr + k) % NREQ]) pick = (m_ptr + k) % NREQ;
`ifdef URAM_ACCESS_CTRL_RAW_STALL_EN
            if (pick >= 0 && bus.wr_req && slice(bus.rd_addr, pick) == bus.wr_addr) pick = -1;
`endif
            if (pick >= 0) begin
                eg[pick] = 1'b1;
                r.due  = cyc + RD_LAT;
                r.id   = pick;
                r.data = m_mem[slice(bus.rd_addr, pick)];
                q.push_back(r);
                m_ptr = (pick + 1) % NREQ;
            end
            if (bus.wr_req) m_mem[bus.wr_addr] = bus.wr_data;
        end
        check("rd_gnt", bus.rd_gnt, eg);
        check("wr_ack", bus.wr_ack, run && bus.wr_req);
        check("init_done", init_done, run);
        check("lat_err", lat_err, m_lat_err);
        due = (q.size() > 0) && (q[0].due == cyc);
        check("rsp_valid", bus.rsp_valid, due);
        if (due) begin
            r = q.pop_front();
            check("rsp_id", bus.rsp_id, r.id);
            if (ram_lat == RD_LAT) check("rsp_data", bus.rsp_data, r.data);
            else m_lat_err = 1'b1;
        end
        if (!rstb) begin
            since_rst = 0;
            m_ptr = 0;
        end else begin
            since_rst++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.wr_req = 1'b0;
            bus.rd_req = '0;
            tick();
        end
    endtask

    task automatic release_and_sweep();
        int writes, done_cyc, rsp_seen;
        writes = 0; done_cyc = -1; rsp_seen = 0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            @(negedge clk);
            if (k == 0) rstb = 1'b1;
            tick();
            if (ram_mem_en && ram_wea) begin
                check("clr_addr", ram_addra, writes);
                check("clr_data", ram_dina, 0);
                writes++;
            end
            if (init_done && done_cyc < 0) done_cyc = k;
            if (bus.rsp_valid) rsp_seen++;
        end
        check("clr_writes", writes, DEPTH);
        check("init_cycle", done_cyc, DEPTH + 1);
        check("clr_no_rsp", rsp_seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gi, prev, off;
        int cnt [NREQ];
        bit granted;

        vt[0] = '{4'b0000, 1'b1, 4'b0000, 1'b1};
        vt[1] = '{4'b1111, 1'b0, 4'b0001, 1'b0};
        vt[2] = '{4'b0001, 1'b1, 4'b0001, 1'b1};
        vt[3] = '{4'b1000, 1'b0, 4'b1000, 1'b0};
        vt[4] = '{4'b0110, 1'b1, 4'b0010, 1'b1};
        vt[5] = '{4'b0110, 1'b0, 4'b0100, 1'b0};
        vt[6] = '{4'b0011, 1'b1, 4'b0001, 1'b1};
        vt[7] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
        vt[8] = '{4'b1010, 1'b1, 4'b0010, 1'b1};
        vt[9] = '{4'b1010, 1'b0, 4'b1000, 1'b0};

        rstb = 1'b0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = '0;   bus.rd_addr = '0;
        repeat (3) begin @(negedge clk); tick(); end
        release_and_sweep();

        // Round-robin vector table; writes of zero to address 15 alongside.
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(i));
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            bus.rd_req = vt[v].req; bus.wr_req = vt[v].wr;
            bus.wr_addr = AW'(15); bus.wr_data = '0;
            tick();
            check("tbl_gnt", bus.rd_gnt, vt[v].gnt);
            check("tbl_ack", bus.wr_ack, vt[v].ack);
        end
        idle(RD_LAT + 2);

        // Read back every cleared address.
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            bus.wr_req = 1'b0;
            bus.rd_req = NREQ'(1) << (a % NREQ);
            set_addr(a % NREQ, AW'(a));
            tick();
        end
        idle(RD_LAT + 2);

        // Write then read address 5 from requester 2; measure latency.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = AW'(5); bus.wr_data = 32'hA5A5A5A5;
        tick();
        idle(3);
        @(negedge clk);
        bus.rd_req = 4'b0100; set_addr(2, AW'(5));
        tick();
        check("a5_gnt", bus.rd_gnt, 4'b0100);
        lat = -1;
        for (int k = 1; k <= RD_LAT + 3; k++) begin
            @(negedge clk);
            bus.rd_req = '0;
            tick();
            if (bus.rsp_valid && lat < 0) begin
                lat = k;
                check("a5_id", bus.rsp_id, 2);
                check("a5_data", bus.rsp_data, 32'hA5A5A5A5);
            end
        end
        check("a5_latency", lat, RD_LAT);
        check("a5_lat_err", lat_err, 1'b0);

        // All requesters held: strict rotation, equal share.
        prev = -1;
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            bus.rd_req = '1;
            for (int i = 0; i < NREQ; i++) set_addr(i, AW'(k + i));
            tick();
            gi = -1;
            for (int i = 0; i < NREQ; i++) if (bus.rd_gnt[i]) gi = i;
            check("rr_onehot", $countones(bus.rd_gnt), 1);
            if (prev >= 0) check("rr_order", gi, (prev + 1) % NREQ);
            if (gi >= 0) cnt[gi]++;
            prev = gi;
        end
        for (int i = 0; i < NREQ; i++) check("rr_share", cnt[i], 3);
        idle(RD_LAT + 2);

        // Same-cycle write and read of address 9.
        @(negedge clk);
        bus.wr_req = 1'b1; bus.wr_addr = AW'(9); bus.wr_data = 32'h22;
        tick();
        idle(2);
        granted = 1'b0; off = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.wr_req = (k == 0); bus.wr_addr = AW'(9); bus.wr_data = 32'h11;
            bus.rd_req = granted ? 4'b0000 : 4'b0010;
            set_addr(1, AW'(9));
            tick();
            if (!granted && bus.rd_gnt[1]) begin granted = 1'b1; off = k; end
        end
        check("raw_gnt_offset", off, EXP_RAW_OFF);
        lat = -1;
        for (int k = 0; k < RD_LAT + 4; k++) begin
            @(negedge clk);
            bus.wr_req = 1'b0; bus.rd_req = '0;
            tick();
            if (bus.rsp_valid && lat < 0) begin
                lat = k;
                check("raw_data", bus.rsp_data, EXP_RAW_DATA);
            end
        end
        check("raw_rsp_seen", lat >= 0, 1'b1);

        // Randomised traffic against the scoreboard.
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            bus.rd_req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) set_addr(i, AW'($urandom_range(DEPTH - 1)));
            bus.wr_req  = ($urandom_range(1) == 1);
            bus.wr_addr = AW'($urandom_range(DEPTH - 1));
            bus.wr_data = $urandom;
            tick();
        end
        idle(RD_LAT + 2);

        // Reset with three reads in flight.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.rd_req = NREQ'(1) << k; set_addr(k, AW'(k + 4));
            tick();
        end
        @(negedge clk);
        rstb = 1'b0; bus.rd_req = '0;
        tick();
        check("midrst_rsp", bus.rsp_valid, 1'b0);
        check("midrst_init", init_done, 1'b0);
        @(negedge clk);
        tick();
        release_and_sweep();

        // RAM one cycle slower than the tag pipeline.
        ram_lat = RD_LAT + 1;
        @(negedge clk);
        bus.rd_req = 4'b0001; set_addr(0, AW'(3));
        tick();
        check("slow_pre_err", lat_err, 1'b0);
        idle(RD_LAT + 4);
        check("slow_err_sticky", lat_err, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
